// File: rtl/bit_counter_param_pkg.sv
// Shared definitions for the parametrised population counter.
//   state_e : FSM encoding (ST_IDLE, ST_RUN, ST_DONE)
//   clog2   : ceiling log2, usable in constant expressions (clog2(1) = 0)
package bit_counter_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_counter_param_if.sv
// Request/result bundle of the population counter.
//   i_start  : start request
//   i_data   : word to count (DATA_W bits)
//   i_mode   : 0 = count ones, 1 = count zeros
//   i_abort  : cancel a count in progress / suppress a start
//   o_busy   : counter is running
//   o_done   : one-cycle completion pulse, o_sum valid alongside
//   o_sum    : last completed count (SUM_W bits)
// master drives the requests and observes results; slave is the counter.
interface bit_counter_param_if #(
    parameter int unsigned DATA_W = 8
);
    import bit_counter_param_pkg::*;

    localparam int unsigned SUM_W = clog2(DATA_W + 1);

    logic              i_start;
    logic [DATA_W-1:0] i_data;
    logic              i_mode;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic [SUM_W-1:0]  o_sum;

    modport master (
        output i_start,
        output i_data,
        output i_mode,
        output i_abort,
        input  o_busy,
        input  o_done,
        input  o_sum
    );

    modport slave (
        input  i_start,
        input  i_data,
        input  i_mode,
        input  i_abort,
        output o_busy,
        output o_done,
        output o_sum
    );

endinterface

// File: rtl/bit_counter_param_popcount_chunk.sv
// Combinational popcount of a W-bit slice.
//   bits_i  : slice to count (W bits)
//   count_o : number of ones in bits_i (clog2(W+1) bits)
module bit_counter_param_popcount_chunk
    import bit_counter_param_pkg::*;
#(
    parameter  int unsigned W     = 1,
    localparam int unsigned OUT_W = clog2(W + 1)
) (
    input  logic [W-1:0]     bits_i,
    output logic [OUT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            count_o = count_o + OUT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/bit_counter_param.sv
// Sequential population counter. A DATA_W-bit word is captured on an accepted
// start (inverted first when counting zeros) and consumed BITS_PER_CYC bits per
// clock; the finished count is published on o_sum with a one-cycle o_done.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : slave side of bit_counter_param_if (start/data/mode/abort in,
//           busy/done/sum out)
// Parameters:
//   DATA_W       : word width, >= 2
//   BITS_PER_CYC : bits consumed per RUN cycle, must divide DATA_W
//   EARLY_EXIT   : 1 = finish once all unconsumed bits are zero
module bit_counter_param
    import bit_counter_param_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned BITS_PER_CYC = 1,
    parameter int unsigned EARLY_EXIT   = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    bit_counter_param_if.slave bus
);

    localparam int unsigned SUM_W   = clog2(DATA_W + 1);
    localparam int unsigned STEPS   = DATA_W / BITS_PER_CYC;
    localparam int unsigned CNT_W   = clog2(STEPS + 1);
    localparam int unsigned CHUNK_W = clog2(BITS_PER_CYC + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CHUNK_W-1:0]  chunk_cnt;
    logic [SUM_W-1:0]    acc_next;
    logic [DATA_W-1:0]   shreg_shifted;
    logic                last_step;

    bit_counter_param_popcount_chunk #(
        .W (BITS_PER_CYC)
    ) u_popcount (
        .bits_i  (shreg_q[BITS_PER_CYC-1:0]),
        .count_o (chunk_cnt)
    );

    // The accumulator is wide enough for DATA_W, so the add cannot wrap.
    assign acc_next      = acc_q + SUM_W'(chunk_cnt);
    assign shreg_shifted = shreg_q >> BITS_PER_CYC;
    assign last_step     = (cnt_q == CNT_W'(STEPS - 1)) ||
                           ((EARLY_EXIT != 0) && (shreg_shifted == '0));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Abort has priority over start; DONE always drops back to IDLE.
                if (bus.i_start && !bus.i_abort) begin
                    shreg_d = bus.i_mode ? ~bus.i_data : bus.i_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.i_abort) begin
                    // o_sum is left untouched so the previous result survives.
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = acc_next;
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        sum_d   = acc_next;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they never glitch
        // on multi-bit state transitions.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign bus.o_sum  = sum_q;

endmodule

// File: tb/tb_bit_counter_param.sv
// Bench for bit_counter_param: three instances (BPC=1, BPC=4, BPC=1 with early
// exit). Expected sum and completion cycle are queued per instance when a start
// is accepted and compared when that instance pulses o_done.
module tb_bit_counter_param;

    typedef struct {
        int sum;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [2:0] mode_v;
    logic [2:0] abort_v;
    logic [7:0] data_v [3];
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [3:0] sum_v [3];

    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];

    bit_counter_param_if #(.DATA_W(8)) bus0 ();
    bit_counter_param_if #(.DATA_W(8)) bus1 ();
    bit_counter_param_if #(.DATA_W(8)) bus2 ();

    assign bus0.i_start = start_v[0];
    assign bus0.i_data  = data_v[0];
    assign bus0.i_mode  = mode_v[0];
    assign bus0.i_abort = abort_v[0];
    assign busy_v[0]    = bus0.o_busy;
    assign done_v[0]    = bus0.o_done;
    assign sum_v[0]     = bus0.o_sum;

    assign bus1.i_start = start_v[1];
    assign bus1.i_data  = data_v[1];
    assign bus1.i_mode  = mode_v[1];
    assign bus1.i_abort = abort_v[1];
    assign busy_v[1]    = bus1.o_busy;
    assign done_v[1]    = bus1.o_done;
    assign sum_v[1]     = bus1.o_sum;

    assign bus2.i_start = start_v[2];
    assign bus2.i_data  = data_v[2];
    assign bus2.i_mode  = mode_v[2];
    assign bus2.i_abort = abort_v[2];
    assign busy_v[2]    = bus2.o_busy;
    assign done_v[2]    = bus2.o_done;
    assign sum_v[2]     = bus2.o_sum;

    bit_counter_param #(.DATA_W(8), .BITS_PER_CYC(1), .EARLY_EXIT(0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    bit_counter_param #(.DATA_W(8), .BITS_PER_CYC(4), .EARLY_EXIT(0)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    bit_counter_param #(.DATA_W(8), .BITS_PER_CYC(1), .EARLY_EXIT(1)) u_dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference: count of selected bits and number of RUN cycles to completion.
    function automatic void model(input logic [7:0] d, input logic m, input int bpc,
                                  input bit ee, output int sum, output int steps);
        logic [7:0] w;
        int hi;
        w   = m ? ~d : d;
        sum = 0;
        hi  = -1;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) begin
                sum++;
                hi = i;
            end
        end
        steps = 8 / bpc;
        if (ee) steps = (hi < 0) ? 1 : (hi / bpc) + 1;
    endfunction

    // Caller is in the low phase; start is sampled at the next rising edge.
    task automatic start_dut(input int k, input logic [7:0] d, input logic m, input bit expect_done);
        int   s;
        int   st;
        exp_t e;
        start_v[k] = 1'b1;
        data_v[k]  = d;
        mode_v[k]  = m;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        data_v[k]  = 8'($urandom);
        mode_v[k]  = 1'($urandom);
        if (expect_done) begin
            model(d, m, (k == 1) ? 4 : 1, (k == 2), s, st);
            e.sum = s;
            e.cyc = cyc + st;
            case (k)
                0:       exp_q0.push_back(e);
                1:       exp_q1.push_back(e);
                default: exp_q2.push_back(e);
            endcase
        end
    endtask

    task automatic wait_done(input int k, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[k] && n < bound);
        if (!done_v[k]) check_val($sformatf("timeout_dut%0d", k), done_v[k], 1);
    endtask

    task automatic mon(input int k);
        exp_t e;
        int   sz;
        if (done_v[k]) begin
            case (k)
                0:       sz = exp_q0.size();
                1:       sz = exp_q1.size();
                default: sz = exp_q2.size();
            endcase
            if (sz == 0) begin
                check_val($sformatf("unexpected_done_dut%0d", k), done_v[k], 0);
            end else begin
                case (k)
                    0:       e = exp_q0.pop_front();
                    1:       e = exp_q1.pop_front();
                    default: e = exp_q2.pop_front();
                endcase
                check_val($sformatf("sum_dut%0d", k), sum_v[k], e.sum);
                check_val($sformatf("done_cycle_dut%0d", k), cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) mon(k);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        start_v = '0;
        mode_v  = '0;
        abort_v = '0;
        for (int k = 0; k < 3; k++) data_v[k] = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("rst_busy_dut%0d", k), busy_v[k], 0);
            check_val($sformatf("rst_done_dut%0d", k), done_v[k], 0);
            check_val($sformatf("rst_sum_dut%0d", k), sum_v[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // All ones: busy for exactly 8 cycles, then sum 8.
        start_dut(0, 8'hFF, 1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_v[0]) n++;
            if (done_v[0]) break;
        end
        check_val("t1_busy_cycles", n, 8);
        @(negedge clk);

        // Abort in the third RUN cycle: back to IDLE, no done, sum keeps 8.
        start_dut(0, 8'h3C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        check_val("t4_busy_after_abort", busy_v[0], 0);
        repeat (10) @(negedge clk);
        check_val("t4_sum_kept", sum_v[0], 8);
        // Start and abort together in IDLE: start is suppressed.
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        data_v[0]  = 8'hAA;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check_val("t4_start_abort_busy", busy_v[0], 0);
        repeat (10) @(negedge clk);
        check_val("t4_start_abort_sum", sum_v[0], 8);

        // Count zeros of 8'b00111000 -> 5, held afterwards.
        start_dut(0, 8'b00111000, 1'b1, 1'b1);
        wait_done(0, 20);
        repeat (3) @(negedge clk);
        check_val("t2_sum_held", sum_v[0], 5);
        check_val("t2_done_low", done_v[0], 0);

        // Asynchronous reset mid-RUN clears outputs before any clock edge.
        start_dut(0, 8'h03, 1'b0, 1'b0);
        @(negedge clk);
        check_val("t5_busy_before_rst", busy_v[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_rst_busy", busy_v[0], 0);
        check_val("t5_rst_done", done_v[0], 0);
        check_val("t5_rst_sum", sum_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_dut(0, 8'h0F, 1'b0, 1'b1);
        wait_done(0, 20);
        @(negedge clk);

        // Four bits per cycle, then a back-to-back start while in DONE.
        start_dut(1, 8'h0F, 1'b0, 1'b1);
        wait_done(1, 10);
        start_dut(1, 8'h00, 1'b0, 1'b1);
        check_val("t3_b2b_busy", busy_v[1], 1);
        wait_done(1, 10);
        @(negedge clk);

        // Early exit: finish once the unconsumed bits are all zero.
        start_dut(2, 8'b00000011, 1'b0, 1'b1);
        wait_done(2, 20);
        @(negedge clk);
        start_dut(2, 8'h00, 1'b0, 1'b1);
        wait_done(2, 20);
        @(negedge clk);
        start_dut(2, 8'h80, 1'b0, 1'b1);
        wait_done(2, 20);
        @(negedge clk);
        start_dut(2, 8'hFF, 1'b1, 1'b1);
        wait_done(2, 20);
        @(negedge clk);

        // Random words and modes across all instances.
        for (int i = 0; i < 9; i++) begin
            start_dut(i % 3, 8'($urandom), 1'($urandom), 1'b1);
            wait_done(i % 3, 20);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check_val("pending_dut0", exp_q0.size(), 0);
        check_val("pending_dut1", exp_q1.size(), 0);
        check_val("pending_dut2", exp_q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
